decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter SEL_W, default 2, select width; SHALL be 1..6.
REQ-002 Parameter DWELL, default 4, cycles each channel stays active in scan mode; SHALL be >= 1.
REQ-003 Derived constant OUT_W = 2**SEL_W; SHALL NOT be overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  high = outputs driven; low = outputs idle, position and dwell count frozen.
REQ-007 load  input  1  one-cycle strobe; captures select and mode.
REQ-008 mode  input  1  sampled on load only: 0 = direct hold, 1 = auto-scan.
REQ-009 select  input  SEL_W  channel index captured on load.
REQ-010 out  output  OUT_W  registered one-hot channel enable.
REQ-011 index  output  SEL_W  registered current channel number.
REQ-012 valid  output  1  registered; high when out carries an active one-hot code.
REQ-013 wrap  output  1  registered one-cycle pulse when scan advances from OUT_W-1 to 0.

Function
REQ-014 States: IDLE, DIRECT, SCAN; the state register SHALL change only on rst or load.
REQ-015 load with enable high: next cycle index = select, out = 1 << select, valid = 1; latency exactly 1 cycle; dwell counter cleared; state = DIRECT (mode 0) or SCAN (mode 1).
REQ-016 load with enable low: index, state and dwell counter SHALL update as in REQ-015; out = 0, valid = 0.
REQ-017 DIRECT: out and index SHALL hold until the next load or rst; wrap = 0.
REQ-018 SCAN: dwell counter counts enabled cycles 0..DWELL-1; at DWELL-1, next cycle index = (index+1) mod OUT_W, out shifts correspondingly, counter returns to 0.
REQ-019 Advance from OUT_W-1 to 0 SHALL assert wrap for exactly that one cycle.
REQ-020 IDLE: out = 0, valid = 0, wrap = 0 regardless of enable.
REQ-021 enable low in DIRECT/SCAN: next cycle out = 0, valid = 0, wrap = 0; index and counter frozen; on enable rising, out SHALL re-assert on the frozen index after 1 cycle and the dwell count SHALL resume from its frozen value.
REQ-022 load coinciding with dwell expiry: load wins; no advance, no wrap.
REQ-023 DWELL = 1: advance on every enabled cycle.
REQ-024 out SHALL be exactly one-hot whenever valid = 1 and all-zero whenever valid = 0 (see REQ-029 for the inverted build).

Reset
REQ-025 rst high SHALL set state = IDLE, out = 0, index = 0, valid = 0, wrap = 0 and dwell counter = 0 on the next edge.
REQ-026 rst SHALL take priority over load and enable in the same cycle, including mid-scan.

Configuration
REQ-027 Macro DECODER_SCAN_ACTIVE_LOW_EN.
REQ-028 Macro undefined: out is active-high as specified above.
REQ-029 Macro defined: out = bitwise inverse of the active-high value, so idle/reset value = all ones and the active channel is a single zero; index, valid, wrap and all timing SHALL be unchanged.

Structure
REQ-030 Shared package decoder_pkg SHALL hold the state enumeration (IDLE, DIRECT, SCAN) and the maximum SEL_W constant (6).
REQ-031 Sub-module onehot_dec (parameter SEL_W, combinational index -> one-hot) SHALL be instantiated once; the output register lives in decoder_scan.

Verification
REQ-032 SEL_W=2: rst; load=1, mode=0, select=2, enable=1 -> next cycle out=0100, index=2, valid=1; the values SHALL hold for 20 cycles.
REQ-033 SEL_W=2, DWELL=3: load with mode=1, select=3 -> out=1000 for 3 cycles, then 0001 with wrap=1 for one cycle, then 0010 three cycles later.
REQ-034 Scan as in REQ-033: drop enable for 5 cycles mid-dwell -> out=0000, valid=0; restore -> same channel resumes and completes only the remaining dwell count.
REQ-035 load asserted on the dwell-expiry cycle with select=1 -> out=0010 next cycle; no advance, wrap=0.
REQ-036 rst asserted mid-scan together with load -> out=0, index=0, valid=0, state IDLE.
REQ-037 Macro defined, SEL_W=3, load with select=5 -> out=11011111; reset value = 11111111.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types for the channel decoder/scanner.
// State enumeration and select-width ceiling.
package decoder_pkg;

  localparam int SEL_W_MAX = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_scan_if.sv
// Control and channel-output bundle for decoder_scan.
// master drives controls, slave is the decoder.
interface decoder_scan_if #(
  parameter int SEL_W = 2
);
  localparam int OUT_W = 1 << SEL_W;

  logic             enable;
  logic             load;
  logic             mode;
  logic [SEL_W-1:0] select;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] index;
  logic             valid;
  logic             wrap;

  modport master (
    output enable, load, mode, select,
    input  out, index, valid, wrap
  );

  modport slave (
    input  enable, load, mode, select,
    output out, index, valid, wrap
  );

endinterface

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational channel index to one-hot decoder.
module onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel_i,
  output logic [(1<<SEL_W)-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// One-hot channel decoder with direct-hold and auto-scan.
// DECODER_SCAN_ACTIVE_LOW_EN inverts the out bus.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input logic           clk,
  input logic           rst,
  decoder_scan_if.slave bus
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DWELL - 1);

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] OUT_IDLE = '1;
`else
  localparam logic [OUT_W-1:0] OUT_IDLE = '0;
`endif

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] dec;

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel_i    (idx_d),
    .onehot_o (dec)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (bus.load) begin
      // load beats dwell expiry in the same cycle
      state_d = bus.mode ? SCAN : DIRECT;
      idx_d   = bus.select;
      cnt_d   = '0;
      valid_d = bus.enable;
    end else begin
      unique case (state_q)
        IDLE: ;
        DIRECT: valid_d = bus.enable;
        SCAN: begin
          valid_d = bus.enable;
          if (bus.enable) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d  = '0;
              idx_d  = idx_q + 1'b1;
              wrap_d = &idx_q;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    out_d = valid_d ? ~dec : OUT_IDLE;
`else
    out_d = valid_d ? dec : OUT_IDLE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= OUT_IDLE;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.index = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed plus random checks of decoder_scan
// against a cycle-level channel/dwell model.
module tb_decoder_scan;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam int SEL_W = 3;
`else
  localparam int SEL_W = 2;
`endif
  localparam int DWELL = 3;
  localparam int OUT_W = 1 << SEL_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_scan_if #(.SEL_W(SEL_W)) bus ();

  decoder_scan #(
    .SEL_W (SEL_W),
    .DWELL (DWELL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int passed = 0;

  // model: 0 idle, 1 direct, 2 scan
  int m_st  = 0;
  int m_ch  = 0;
  int m_cnt = 0;
  logic m_valid = 1'b0;
  logic m_wrap  = 1'b0;

  function automatic logic [OUT_W-1:0] act(int ch);
    logic [OUT_W-1:0] v;
    v = '0;
    v[ch] = 1'b1;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    v = ~v;
`endif
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] idle_out();
    logic [OUT_W-1:0] v;
    v = '0;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    v = ~v;
`endif
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic model(input logic r, input logic en,
                       input logic ld, input logic md,
                       input int sel);
    m_wrap = 1'b0;
    if (r) begin
      m_st = 0; m_ch = 0; m_cnt = 0;
      m_valid = 1'b0;
    end else if (ld) begin
      m_st = md ? 2 : 1;
      m_ch = sel; m_cnt = 0;
      m_valid = en;
    end else begin
      m_valid = (m_st != 0) && en;
      if (m_st == 2 && en) begin
        m_cnt++;
        if (m_cnt == DWELL) begin
          m_cnt = 0;
          m_wrap = (m_ch == OUT_W - 1);
          m_ch = (m_ch + 1) % OUT_W;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic en,
                     input logic ld, input logic md,
                     input int sel);
    logic [OUT_W-1:0] eo;
    rst        = r;
    bus.enable = en;
    bus.load   = ld;
    bus.mode   = md;
    bus.select = SEL_W'(sel);
    @(posedge clk);
    model(r, en, ld, md, sel);
    #1;
    eo = m_valid ? act(m_ch) : idle_out();
    chk("out", 64'(bus.out), 64'(eo));
    chk("index", 64'(bus.index), 64'(m_ch));
    chk("valid", 64'(bus.valid), 64'(m_valid));
    chk("wrap", 64'(bus.wrap), 64'(m_wrap));
    rst      = 1'b0;
    bus.load = 1'b0;
  endtask

  task automatic run(input logic en, input int n);
    for (int i = 0; i < n; i++) cyc(0, en, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.load = 1'b0;
    bus.mode = 1'b0;
    bus.select = '0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1);
    chk("rst_out", 64'(bus.out), 64'(idle_out()));
    chk("rst_idx", 64'(bus.index), 64'd0);
    run(1, 2);
    chk("idle_valid", 64'(bus.valid), 64'd0);

    // direct hold
    cyc(0, 1, 1, 0, 2);
    chk("dir_out", 64'(bus.out), 64'(act(2)));
    run(1, 20);
    chk("dir_hold", 64'(bus.out), 64'(act(2)));
    chk("dir_idx", 64'(bus.index), 64'd2);

    // scan from top channel through wrap
    cyc(0, 1, 1, 1, OUT_W - 1);
    run(1, 2);
    chk("scan_top", 64'(bus.out), 64'(act(OUT_W-1)));
    run(1, 1);
    chk("wrap_pulse", 64'(bus.wrap), 64'd1);
    chk("wrap_idx", 64'(bus.index), 64'd0);
    run(1, 1);
    chk("wrap_end", 64'(bus.wrap), 64'd0);
    run(1, 2);
    chk("scan_ch1", 64'(bus.index), 64'd1);

    // pause mid-dwell then resume
    run(1, 1);
    run(0, 5);
    chk("pause_out", 64'(bus.out), 64'(idle_out()));
    chk("pause_valid", 64'(bus.valid), 64'd0);
    run(1, 1);
    chk("resume_ch", 64'(bus.out), 64'(act(1)));
    run(1, 1);
    chk("resume_adv", 64'(bus.index), 64'd2);

    // load on dwell expiry
    run(1, 2);
    cyc(0, 1, 1, 1, 1);
    chk("ld_exp_out", 64'(bus.out), 64'(act(1)));
    chk("ld_exp_wrap", 64'(bus.wrap), 64'd0);

    // reset beats load mid-scan
    run(1, 1);
    cyc(1, 1, 1, 1, 3);
    chk("rst_ld_out", 64'(bus.out), 64'(idle_out()));
    chk("rst_ld_idx", 64'(bus.index), 64'd0);
    run(1, 2);
    chk("rst_ld_idle", 64'(bus.valid), 64'd0);

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    cyc(0, 1, 1, 0, 5);
    chk("inv_sel5", 64'(bus.out), 64'h0DF);
`endif

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(99) < 2),
          ($urandom_range(99) < 80),
          ($urandom_range(99) < 10),
          1'($urandom),
          int'($urandom_range(OUT_W - 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
